rob_commit: RTL and testbench
=============================

Name: rob_commit

Overview:
- 2-wide in-order reorder buffer and commit unit for the superscalar backend.
- Accepts renamed uOP pairs from register_rename/dispatch and marks entries complete from two writeback ports.
- Retires up to two entries per cycle in program order.
- Drives the commit interface back into register_rename (commit_valid_*, old physical register to free), which is the return path of the rename protocol.

Parameters:
- DEPTH, 16, number of ROB entries; power of two, >= 4
- IDX_W, 4, log2(DEPTH); width of ROB index
- PREG_W, 6, physical register index width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- recover  in  1  flush all in-flight entries (mispredict/exception)
- alloc_valid_0, alloc_valid_1  in  1  allocation request, lane 0/1
- alloc_wen_0, alloc_wen_1  in  1  uOP writes a destination register
- alloc_lreg_0, alloc_lreg_1  in  5  logical destination
- alloc_preg_0, alloc_preg_1  in  PREG_W  new physical destination
- alloc_old_preg_0, alloc_old_preg_1  in  PREG_W  previous mapping of lreg
- alloc_pc_0, alloc_pc_1  in  32  uOP PC
- alloc_ready  out  1  at least two free entries
- alloc_id_0, alloc_id_1  out  IDX_W  ROB index assigned to lane 0/1 this cycle
- wb_valid_0, wb_valid_1  in  1  completion strobe
- wb_id_0, wb_id_1  in  IDX_W  ROB index completed
- commit_valid_0, commit_valid_1  out  1  retire strobe, program order
- commit_wen_0, commit_wen_1  out  1  retired uOP wrote a register
- commit_lreg_0, commit_lreg_1  out  5
- commit_preg_0, commit_preg_1  out  PREG_W
- commit_old_preg_0, commit_old_preg_1  out  PREG_W  register to return to free list
- commit_pc_0, commit_pc_1  out  32
- count  out  IDX_W+1  occupied entries
- empty  out  1  count == 0

Behaviour:
- Reset (rst=1 at posedge): head=tail=0, count=0, all entry valid/done bits cleared, every commit_* output 0. Consequently alloc_ready=1 and empty=1.
- Entry state: valid, done, wen, lreg, preg, old_preg, pc.
- alloc_ready is combinational: (DEPTH - count) >= 2, using the registered count (this cycle's commits do not count).
- Allocation is accepted only when alloc_ready=1 and recover=0. Otherwise requests are dropped, and the upstream stage must hold.
- Accepted lanes are packed in lane order:
  - lane 0 is written to tail;
  - lane 1 is written to tail+1 if lane 0 is valid, else to tail.
  - tail advances by the number accepted, modulo DEPTH (wraps DEPTH-1 -> 0).
- alloc_id_0 = tail. alloc_id_1 = tail+1 if alloc_valid_0, else tail. Both are combinational.
- Writeback: wb_valid_x sets done[wb_id_x] at the posedge, but only if valid[wb_id_x]=1. A writeback to an invalid entry is ignored. Both ports may hit any entries; if both hit the same entry, the result equals a single hit.
- Commit decision, combinational in cycle t:
  - c0 = valid[head] & done[head].
  - c1 = c0 & valid[head+1] & done[head+1].
  - Lane 1 never commits without lane 0.
- At the posedge ending cycle t:
  - the chosen entries are cleared;
  - head advances by c0+c1;
  - commit_*_0/1 register the entry fields, with commit_valid = c0/c1.
  - Commit outputs are therefore visible in cycle t+1; all fields are 0 when the matching valid is 0.
- Latency: wb at cycle t -> done set after edge t -> commit decided in t+1 -> commit_valid visible in t+2.
- A writeback arriving in the same cycle the entry is evaluated for commit is not seen until the next cycle.
- count_next = count + accepted - committed. Simultaneous alloc and commit in one cycle is legal, including at count == DEPTH-1 or DEPTH.
- Full (count == DEPTH): alloc_ready=0, and commits proceed normally.
- Empty: no commits, and commit_valid_* go to 0.
- recover=1 at posedge:
  - head=tail=0, count=0, all valid/done cleared;
  - commit_* outputs are 0 next cycle;
  - same-cycle alloc, wb and commit are discarded.
  - The flush takes priority over everything except rst.
- rst mid-operation: identical to recover, plus all outputs are cleared. rst has priority over recover.

Test Plan:
- Reset with alloc_valid held at 1 -> no entries allocated; count=0, alloc_ready=1, empty=1, commit_valid_0/1=0.
- Two allocation cycles, 4 uOPs with PCs 0,4,8,C at ids 0..3. Writeback id3, then id1, then id0, then id2, each one cycle apart:
  - no commit until id0 is done;
  - then PC 0 and 4 commit together (commit_valid_0=1, commit_valid_1=1);
  - then PC 8 and C commit together;
  - commit_old_preg values match the allocated ones.
- Single-lane allocate (alloc_valid_1 only) with PC 40 -> alloc_id_1 = tail; after its wb, the entry commits on lane 0 with commit_valid_1=0.
- Fill to count=15 -> alloc_ready=0. Writeback the head, then during its commit cycle present no alloc; count drops to 14 and alloc_ready returns to 1.
- Wrap: start with head=tail=14, allocate 4 -> ids 14,15,0,1. Writeback all -> in-order commits across the 15->0 boundary; count ends at 0.
- 6 entries in flight, 2 done, with recover pulsed in the same cycle as an alloc pair and a wb -> next cycle count=0, empty=1, commit_valid=0, tail=0. The next allocation gets ids 0 and 1.

Source files
------------

// File: rtl/rob_commit.sv
// rob_commit: 2-wide in-order reorder buffer. Dual allocation, dual writeback and
// dual in-order retirement; commit outputs are registered, alloc_ready/alloc_id are combinational.
module rob_commit #(
    parameter int DEPTH  = 16,
    parameter int IDX_W  = 4,
    parameter int PREG_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              recover,
    input  logic              alloc_valid_0,
    input  logic              alloc_valid_1,
    input  logic              alloc_wen_0,
    input  logic              alloc_wen_1,
    input  logic [4:0]        alloc_lreg_0,
    input  logic [4:0]        alloc_lreg_1,
    input  logic [PREG_W-1:0] alloc_preg_0,
    input  logic [PREG_W-1:0] alloc_preg_1,
    input  logic [PREG_W-1:0] alloc_old_preg_0,
    input  logic [PREG_W-1:0] alloc_old_preg_1,
    input  logic [31:0]       alloc_pc_0,
    input  logic [31:0]       alloc_pc_1,
    output logic              alloc_ready,
    output logic [IDX_W-1:0]  alloc_id_0,
    output logic [IDX_W-1:0]  alloc_id_1,
    input  logic              wb_valid_0,
    input  logic              wb_valid_1,
    input  logic [IDX_W-1:0]  wb_id_0,
    input  logic [IDX_W-1:0]  wb_id_1,
    output logic              commit_valid_0,
    output logic              commit_valid_1,
    output logic              commit_wen_0,
    output logic              commit_wen_1,
    output logic [4:0]        commit_lreg_0,
    output logic [4:0]        commit_lreg_1,
    output logic [PREG_W-1:0] commit_preg_0,
    output logic [PREG_W-1:0] commit_preg_1,
    output logic [PREG_W-1:0] commit_old_preg_0,
    output logic [PREG_W-1:0] commit_old_preg_1,
    output logic [31:0]       commit_pc_0,
    output logic [31:0]       commit_pc_1,
    output logic [IDX_W:0]    count,
    output logic              empty
);

    localparam int CNT_W  = IDX_W + 1;
    localparam int LANE_W = 1 + 1 + 5 + PREG_W + PREG_W + 32;

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [DEPTH-1:0]  done_q, done_d;
    logic              wen_q      [DEPTH];
    logic [4:0]        lreg_q     [DEPTH];
    logic [PREG_W-1:0] preg_q     [DEPTH];
    logic [PREG_W-1:0] old_preg_q [DEPTH];
    logic [31:0]       pc_q       [DEPTH];

    logic [IDX_W-1:0]  head_q, head_d, tail_q, tail_d, head1;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              acc0, acc1, com0, com1;
    logic [LANE_W-1:0] lane0_q, lane0_d, lane1_q, lane1_d;

    assign alloc_ready = (count_q <= CNT_W'(DEPTH - 2));
    assign alloc_id_0  = tail_q;
    assign alloc_id_1  = tail_q + IDX_W'(alloc_valid_0);
    assign count       = count_q;
    assign empty       = (count_q == '0);

    assign acc0  = alloc_valid_0 & alloc_ready & ~recover;
    assign acc1  = alloc_valid_1 & alloc_ready & ~recover;
    assign head1 = head_q + IDX_W'(1);
    assign com0  = valid_q[head_q] & done_q[head_q];
    assign com1  = com0 & valid_q[head1] & done_q[head1];

    // Writeback first, then retire clears, then allocation: allocation can never
    // target a retiring slot because alloc_ready is low whenever the ROB is full.
    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        if (wb_valid_0 && valid_q[wb_id_0]) done_d[wb_id_0] = 1'b1;
        if (wb_valid_1 && valid_q[wb_id_1]) done_d[wb_id_1] = 1'b1;
        if (com0) begin
            valid_d[head_q] = 1'b0;
            done_d[head_q]  = 1'b0;
        end
        if (com1) begin
            valid_d[head1] = 1'b0;
            done_d[head1]  = 1'b0;
        end
        if (acc0) begin
            valid_d[tail_q] = 1'b1;
            done_d[tail_q]  = 1'b0;
        end
        if (acc1) begin
            valid_d[alloc_id_1] = 1'b1;
            done_d[alloc_id_1]  = 1'b0;
        end
        head_d  = head_q + IDX_W'(com0) + IDX_W'(com1);
        tail_d  = tail_q + IDX_W'(acc0) + IDX_W'(acc1);
        count_d = count_q + CNT_W'(acc0) + CNT_W'(acc1) - CNT_W'(com0) - CNT_W'(com1);
        lane0_d = com0 ? {1'b1, wen_q[head_q], lreg_q[head_q], preg_q[head_q],
                          old_preg_q[head_q], pc_q[head_q]} : '0;
        lane1_d = com1 ? {1'b1, wen_q[head1], lreg_q[head1], preg_q[head1],
                          old_preg_q[head1], pc_q[head1]} : '0;
    end

    always_ff @(posedge clk) begin
        if (rst || recover) begin
            valid_q <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            lane0_q <= '0;
            lane1_q <= '0;
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            lane0_q <= lane0_d;
            lane1_q <= lane1_d;
        end
    end

    // Payload needs no reset: it is only observed through a set valid bit.
    always_ff @(posedge clk) begin
        if (acc0) begin
            wen_q[tail_q]      <= alloc_wen_0;
            lreg_q[tail_q]     <= alloc_lreg_0;
            preg_q[tail_q]     <= alloc_preg_0;
            old_preg_q[tail_q] <= alloc_old_preg_0;
            pc_q[tail_q]       <= alloc_pc_0;
        end
        if (acc1) begin
            wen_q[alloc_id_1]      <= alloc_wen_1;
            lreg_q[alloc_id_1]     <= alloc_lreg_1;
            preg_q[alloc_id_1]     <= alloc_preg_1;
            old_preg_q[alloc_id_1] <= alloc_old_preg_1;
            pc_q[alloc_id_1]       <= alloc_pc_1;
        end
    end

    assign {commit_valid_0, commit_wen_0, commit_lreg_0, commit_preg_0,
            commit_old_preg_0, commit_pc_0} = lane0_q;
    assign {commit_valid_1, commit_wen_1, commit_lreg_1, commit_preg_1,
            commit_old_preg_1, commit_pc_1} = lane1_q;

endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit: directed scenarios plus a randomized phase, all checked every cycle
// against a queue-based program-order model of the ROB.
module tb_rob_commit;

    localparam int DEPTH  = 16;
    localparam int IDX_W  = 4;
    localparam int PREG_W = 6;

    logic              clk = 1'b0;
    logic              rst, recover;
    logic              alloc_valid_0, alloc_valid_1, alloc_wen_0, alloc_wen_1;
    logic [4:0]        alloc_lreg_0, alloc_lreg_1;
    logic [PREG_W-1:0] alloc_preg_0, alloc_preg_1, alloc_old_preg_0, alloc_old_preg_1;
    logic [31:0]       alloc_pc_0, alloc_pc_1;
    logic              alloc_ready;
    logic [IDX_W-1:0]  alloc_id_0, alloc_id_1;
    logic              wb_valid_0, wb_valid_1;
    logic [IDX_W-1:0]  wb_id_0, wb_id_1;
    logic              commit_valid_0, commit_valid_1, commit_wen_0, commit_wen_1;
    logic [4:0]        commit_lreg_0, commit_lreg_1;
    logic [PREG_W-1:0] commit_preg_0, commit_preg_1, commit_old_preg_0, commit_old_preg_1;
    logic [31:0]       commit_pc_0, commit_pc_1;
    logic [IDX_W:0]    count;
    logic              empty;

    always #5 clk = ~clk;

    rob_commit #(.DEPTH(DEPTH), .IDX_W(IDX_W), .PREG_W(PREG_W)) dut (
        .clk(clk), .rst(rst), .recover(recover),
        .alloc_valid_0(alloc_valid_0), .alloc_valid_1(alloc_valid_1),
        .alloc_wen_0(alloc_wen_0), .alloc_wen_1(alloc_wen_1),
        .alloc_lreg_0(alloc_lreg_0), .alloc_lreg_1(alloc_lreg_1),
        .alloc_preg_0(alloc_preg_0), .alloc_preg_1(alloc_preg_1),
        .alloc_old_preg_0(alloc_old_preg_0), .alloc_old_preg_1(alloc_old_preg_1),
        .alloc_pc_0(alloc_pc_0), .alloc_pc_1(alloc_pc_1),
        .alloc_ready(alloc_ready), .alloc_id_0(alloc_id_0), .alloc_id_1(alloc_id_1),
        .wb_valid_0(wb_valid_0), .wb_valid_1(wb_valid_1),
        .wb_id_0(wb_id_0), .wb_id_1(wb_id_1),
        .commit_valid_0(commit_valid_0), .commit_valid_1(commit_valid_1),
        .commit_wen_0(commit_wen_0), .commit_wen_1(commit_wen_1),
        .commit_lreg_0(commit_lreg_0), .commit_lreg_1(commit_lreg_1),
        .commit_preg_0(commit_preg_0), .commit_preg_1(commit_preg_1),
        .commit_old_preg_0(commit_old_preg_0), .commit_old_preg_1(commit_old_preg_1),
        .commit_pc_0(commit_pc_0), .commit_pc_1(commit_pc_1),
        .count(count), .empty(empty)
    );

    typedef struct {
        int                id;
        logic              wen;
        logic [4:0]        lreg;
        logic [PREG_W-1:0] preg;
        logic [PREG_W-1:0] oldp;
        logic [31:0]       pc;
        bit                done;
    } entry_t;

    entry_t      rob[$];
    int          tailM = 0;
    int          checks = 0;
    int          errors = 0;
    logic [63:0] expLane0, expLane1;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] packEntry(input entry_t e);
        return 64'({1'b1, e.wen, e.lreg, e.preg, e.oldp, e.pc});
    endfunction

    task automatic setIdle();
        recover       = 1'b0;
        alloc_valid_0 = 1'b0;
        alloc_valid_1 = 1'b0;
        wb_valid_0    = 1'b0;
        wb_valid_1    = 1'b0;
    endtask

    task automatic setAlloc(input int lane, input logic [31:0] pc);
        if (lane == 0) begin
            alloc_valid_0    = 1'b1;
            alloc_wen_0      = 1'($urandom);
            alloc_lreg_0     = 5'($urandom);
            alloc_preg_0     = PREG_W'($urandom);
            alloc_old_preg_0 = PREG_W'($urandom);
            alloc_pc_0       = pc;
        end else begin
            alloc_valid_1    = 1'b1;
            alloc_wen_1      = 1'($urandom);
            alloc_lreg_1     = 5'($urandom);
            alloc_preg_1     = PREG_W'($urandom);
            alloc_old_preg_1 = PREG_W'($urandom);
            alloc_pc_1       = pc;
        end
    endtask

    task automatic setWb(input int lane, input int id);
        if (lane == 0) begin
            wb_valid_0 = 1'b1;
            wb_id_0    = IDX_W'(id);
        end else begin
            wb_valid_1 = 1'b1;
            wb_id_1    = IDX_W'(id);
        end
    endtask

    // One clock: check combinational outputs before the edge, advance the model,
    // then check the registered commit lanes just after the edge.
    task automatic applyStimulus();
        entry_t e;
        int     nCom;
        bit     ready;
        @(negedge clk);
        ready = (DEPTH - rob.size()) >= 2;
        if (!rst) begin
            checkOutput("count", 64'(count), 64'(rob.size()));
            checkOutput("empty", 64'(empty), 64'(rob.size() == 0));
            checkOutput("alloc_ready", 64'(alloc_ready), 64'(ready));
            checkOutput("alloc_id_0", 64'(alloc_id_0), 64'(tailM));
            checkOutput("alloc_id_1", 64'(alloc_id_1),
                        64'(alloc_valid_0 ? (tailM + 1) % DEPTH : tailM));
        end
        expLane0 = '0;
        expLane1 = '0;
        nCom     = 0;
        if (rst || recover) begin
            rob.delete();
            tailM = 0;
        end else begin
            if (rob.size() >= 1 && rob[0].done) begin
                expLane0 = packEntry(rob[0]);
                nCom = 1;
                if (rob.size() >= 2 && rob[1].done) begin
                    expLane1 = packEntry(rob[1]);
                    nCom = 2;
                end
            end
            for (int i = 0; i < nCom; i++) void'(rob.pop_front());
            for (int i = 0; i < rob.size(); i++) begin
                if (wb_valid_0 && rob[i].id == int'(wb_id_0)) rob[i].done = 1'b1;
                if (wb_valid_1 && rob[i].id == int'(wb_id_1)) rob[i].done = 1'b1;
            end
            if (ready && alloc_valid_0) begin
                e = '{tailM, alloc_wen_0, alloc_lreg_0, alloc_preg_0, alloc_old_preg_0, alloc_pc_0, 1'b0};
                rob.push_back(e);
                tailM = (tailM + 1) % DEPTH;
            end
            if (ready && alloc_valid_1) begin
                e = '{tailM, alloc_wen_1, alloc_lreg_1, alloc_preg_1, alloc_old_preg_1, alloc_pc_1, 1'b0};
                rob.push_back(e);
                tailM = (tailM + 1) % DEPTH;
            end
        end
        @(posedge clk);
        #1;
        checkOutput("commit_lane0", 64'({commit_valid_0, commit_wen_0, commit_lreg_0, commit_preg_0,
                    commit_old_preg_0, commit_pc_0}), expLane0);
        checkOutput("commit_lane1", 64'({commit_valid_1, commit_wen_1, commit_lreg_1, commit_preg_1,
                    commit_old_preg_1, commit_pc_1}), expLane1);
    endtask

    initial begin
        rst = 1'b1;
        setIdle();
        setAlloc(0, 32'h100);
        setAlloc(1, 32'h104);
        wb_id_0 = '0;
        wb_id_1 = '0;
        applyStimulus();
        applyStimulus();
        rst = 1'b0;
        setIdle();
        applyStimulus();
        checkOutput("reset_count", 64'(count), 64'd0);
        checkOutput("reset_ready", 64'(alloc_ready), 64'd1);
        checkOutput("reset_empty", 64'(empty), 64'd1);

        // Four uOPs, out-of-order completion 3,1,0,2.
        setIdle(); setAlloc(0, 32'h0); setAlloc(1, 32'h4); applyStimulus();
        setIdle(); setAlloc(0, 32'h8); setAlloc(1, 32'hC); applyStimulus();
        setIdle(); setWb(0, 3); applyStimulus();
        setIdle(); setWb(0, 1); applyStimulus();
        setIdle(); setWb(0, 0); applyStimulus();
        checkOutput("no_commit_before_id0", 64'(commit_valid_0), 64'd0);
        setIdle(); setWb(1, 2); applyStimulus();
        checkOutput("pair1_valid", 64'({commit_valid_0, commit_valid_1}), 64'b11);
        checkOutput("pair1_pc", {commit_pc_0, commit_pc_1}, {32'h0, 32'h4});
        setIdle(); applyStimulus();
        checkOutput("pair2_valid", 64'({commit_valid_0, commit_valid_1}), 64'b11);
        checkOutput("pair2_pc", {commit_pc_0, commit_pc_1}, {32'h8, 32'hC});
        setIdle(); applyStimulus();

        // Single lane-1 allocation retires on lane 0.
        setIdle(); setAlloc(1, 32'h40); applyStimulus();
        setIdle(); setWb(0, 4); applyStimulus();
        setIdle(); applyStimulus();
        checkOutput("single_valid", 64'({commit_valid_0, commit_valid_1}), 64'b10);
        checkOutput("single_pc", 64'(commit_pc_0), 64'h40);

        // Fill to DEPTH-1, then retire the head with no allocation.
        for (int i = 0; i < 7; i++) begin
            setIdle(); setAlloc(0, 32'h1000 + 8 * i); setAlloc(1, 32'h1004 + 8 * i); applyStimulus();
        end
        setIdle(); setAlloc(0, 32'h2000); applyStimulus();
        checkOutput("fill_count", 64'(count), 64'd15);
        checkOutput("fill_ready", 64'(alloc_ready), 64'd0);
        setIdle(); setWb(0, rob[0].id); setAlloc(0, 32'h3000); setAlloc(1, 32'h3004); applyStimulus();
        setIdle(); applyStimulus();
        checkOutput("drain_count", 64'(count), 64'd14);
        checkOutput("drain_ready", 64'(alloc_ready), 64'd1);
        setIdle(); recover = 1'b1; applyStimulus();

        // Move head/tail to 14, then allocate across the wrap point.
        for (int i = 0; i < 7; i++) begin
            setIdle(); setAlloc(0, 32'h4000 + 8 * i); setAlloc(1, 32'h4004 + 8 * i); applyStimulus();
        end
        for (int i = 0; i < 7; i++) begin
            setIdle(); setWb(0, 2 * i); setWb(1, 2 * i + 1); applyStimulus();
        end
        for (int i = 0; i < 4; i++) begin
            setIdle(); applyStimulus();
        end
        setIdle(); setAlloc(0, 32'h5000); setAlloc(1, 32'h5004);
        #1;
        checkOutput("wrap_ids_a", 64'({alloc_id_0, alloc_id_1}), 64'({4'd14, 4'd15}));
        applyStimulus();
        setIdle(); setAlloc(0, 32'h5008); setAlloc(1, 32'h500C);
        #1;
        checkOutput("wrap_ids_b", 64'({alloc_id_0, alloc_id_1}), 64'({4'd0, 4'd1}));
        applyStimulus();
        setIdle(); setWb(0, 14); setWb(1, 15); applyStimulus();
        setIdle(); setWb(0, 0); setWb(1, 1); applyStimulus();
        for (int i = 0; i < 4; i++) begin
            setIdle(); applyStimulus();
        end
        checkOutput("wrap_count", 64'(count), 64'd0);

        // Recover with six in flight, two of them done, plus same-cycle alloc and wb.
        for (int i = 0; i < 3; i++) begin
            setIdle(); setAlloc(0, 32'h6000 + 8 * i); setAlloc(1, 32'h6004 + 8 * i); applyStimulus();
        end
        setIdle(); setWb(0, rob[2].id); setWb(1, rob[3].id); applyStimulus();
        setIdle(); recover = 1'b1; setAlloc(0, 32'h7000); setAlloc(1, 32'h7004); setWb(0, rob[0].id);
        applyStimulus();
        checkOutput("recover_count", 64'(count), 64'd0);
        checkOutput("recover_empty", 64'(empty), 64'd1);
        checkOutput("recover_commit", 64'({commit_valid_0, commit_valid_1}), 64'b00);
        setIdle(); setAlloc(0, 32'h8000); setAlloc(1, 32'h8004);
        #1;
        checkOutput("recover_ids", 64'({alloc_id_0, alloc_id_1}), 64'({4'd0, 4'd1}));
        applyStimulus();

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            setIdle();
            recover = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 2) != 0) setAlloc(0, $urandom);
            if ($urandom_range(0, 2) != 0) setAlloc(1, $urandom);
            if ($urandom_range(0, 1) != 0) begin
                if (rob.size() > 0) setWb(0, rob[$urandom_range(0, rob.size() - 1)].id);
                else setWb(0, $urandom_range(0, DEPTH - 1));
            end
            if ($urandom_range(0, 3) == 0) setWb(1, $urandom_range(0, DEPTH - 1));
            else if (rob.size() > 0 && $urandom_range(0, 1) != 0)
                setWb(1, rob[$urandom_range(0, rob.size() - 1)].id);
            applyStimulus();
        end
        for (int i = 0; i < 3; i++) begin
            setIdle(); applyStimulus();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
